i2s_xmtr: RTL and testbench

I2S bus master and transmitter, the counterpart of the I2S receiver in the equalizer datapath. It generates I2S_sclk and I2S_ws from the 50 MHz system clock and serializes one 24-bit left/right sample pair per frame on I2S_data, MSB first, in standard I2S format. A single-entry holding register decouples the producer from the frame timing. It drives the receiver in loopback benches and serves as the audio path to an external I2S DAC.

---
 rtl/i2s_xmtr.sv | 143 ++++++++++++++
 tb/tb_i2s_xmtr.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_xmtr.sv
// ---------------------------------------------------------------------------
// i2s_xmtr -- I2S bus master and transmitter.
//
// Generates the I2S bit clock and word select from the system clock. Sends
// one left/right sample pair per frame, MSB first, in standard I2S format
// (word select leads the MSB by one bit clock). A single-entry holding
// register decouples the sample producer from the frame timing. If no new
// pair has arrived by the frame boundary, the previous pair is sent again.
//
// Parameters
//   SCLK_DIV  clk cycles per I2S_sclk period (even, >= 4)
//   SLOT_W    I2S_sclk periods per channel slot
//   DATA_W    sample width (DATA_W <= SLOT_W-1)
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   lft_in     in   left sample (signed, DATA_W)
//   rght_in    in   right sample (signed, DATA_W)
//   wrt        in   single-cycle strobe, captures lft_in/rght_in
//   full       out  holding register occupied
//   frm_start  out  one-cycle pulse after every frame load
//   undrn      out  one-cycle pulse after a frame load that found no new pair
//   I2S_sclk   out  bit clock
//   I2S_ws     out  word select, 0 = left, 1 = right
//   I2S_data   out  serial data, updated on the falling edge of I2S_sclk
// ---------------------------------------------------------------------------
module i2s_xmtr #(
    parameter int SCLK_DIV = 32,
    parameter int SLOT_W   = 32,
    parameter int DATA_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rght_in,
    input  logic              wrt,
    output logic              full,
    output logic              frm_start,
    output logic              undrn,
    output logic              I2S_sclk,
    output logic              I2S_ws,
    output logic              I2S_data
);

    localparam int DCW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BCW = $clog2(2 * SLOT_W);

    localparam logic [DCW-1:0] DIV_RISE = DCW'(SCLK_DIV / 2 - 1);
    localparam logic [DCW-1:0] DIV_FALL = DCW'(SCLK_DIV - 1);
    localparam logic [BCW-1:0] BC_MAX   = BCW'(2 * SLOT_W - 1);
    localparam logic [BCW-1:0] BC_SLOT  = BCW'(SLOT_W);

    logic [DCW-1:0]    div_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] hold_lft, hold_rght;
    logic [DATA_W-1:0] frame_lft, frame_rght;

    logic              rise_evt, fall_evt, load;
    logic [BCW-1:0]    bit_nxt;
    logic [BCW-1:0]    pos;
    logic [DATA_W-1:0] chan;
    logic              ws_nxt, data_nxt;

    assign rise_evt = (div_cnt == DIV_RISE);
    assign fall_evt = (div_cnt == DIV_FALL);
    // A frame load happens on the fall event that wraps bit_cnt back to 0.
    assign load     = fall_evt && (bit_cnt == BC_MAX);

    // Next bit position and the serial value it carries. The frame
    // registers already hold the current pair for every position that
    // carries data: position 0 (the load position) always sends 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        bit_nxt  = (bit_cnt == BC_MAX) ? '0 : bit_cnt + 1'b1;
        ws_nxt   = (bit_nxt >= BC_SLOT);
        pos      = bit_nxt;
        chan     = frame_lft;
        data_nxt = 1'b0;
        if (ws_nxt) begin
            pos  = bit_nxt - BC_SLOT;
            chan = frame_rght;
        end
        // Slot position p (1..DATA_W) carries chan[DATA_W-p], MSB first.
        for (int i = 0; i < DATA_W; i++) begin
            if (pos == BCW'(DATA_W - i)) data_nxt = chan[i];
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge value of the others; this is what lets a load take the
    // old holding contents while a simultaneous wrt refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            bit_cnt    <= BC_MAX;
            I2S_sclk   <= 1'b0;
            I2S_ws     <= 1'b1;
            I2S_data   <= 1'b0;
            full       <= 1'b0;
            frm_start  <= 1'b0;
            undrn      <= 1'b0;
            // NOTE: the sample registers are reset too, because an idle
            // link must transmit zeros rather than stale data after reset.
            hold_lft   <= '0;
            hold_rght  <= '0;
            frame_lft  <= '0;
            frame_rght <= '0;
        end else begin
            frm_start <= load;
            undrn     <= load && !full;

            if (fall_evt) begin
                div_cnt  <= '0;
                I2S_sclk <= 1'b0;
                bit_cnt  <= bit_nxt;
                I2S_ws   <= ws_nxt;
                I2S_data <= data_nxt;
            end else begin
                div_cnt <= div_cnt + 1'b1;
                if (rise_evt) I2S_sclk <= 1'b1;
            end

            // On an underrun the frame registers keep the previous pair.
            if (load && full) begin
                frame_lft  <= hold_lft;
                frame_rght <= hold_rght;
            end

            // A write always lands in the holding register; the latest
            // sample wins over any unsent one.
            if (wrt) begin
                hold_lft  <= lft_in;
                hold_rght <= rght_in;
                full      <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_xmtr.sv
// ---------------------------------------------------------------------------
// tb_i2s_xmtr -- self-checking bench for i2s_xmtr at default parameters.
// Directed scenarios: reset/idle, single frame, underrun repeat, overwrite,
// write in the load cycle, and reset asserted mid-frame.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_i2s_xmtr;

    localparam int DATA_W = 24;
    localparam int FRAME  = 2048;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] lft_in = '0;
    logic [DATA_W-1:0] rght_in = '0;
    logic              wrt = 1'b0;
    logic              full, frm_start, undrn;
    logic              I2S_sclk, I2S_ws, I2S_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_frm = -1;

    i2s_xmtr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_in    (lft_in),
        .rght_in   (rght_in),
        .wrt       (wrt),
        .full      (full),
        .frm_start (frm_start),
        .undrn     (undrn),
        .I2S_sclk  (I2S_sclk),
        .I2S_ws    (I2S_ws),
        .I2S_data  (I2S_data)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected I2S_data per bit_cnt 0..63 (bit b of the result).
    function automatic logic [63:0] exp_bits(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        logic [63:0] e;
        e = '0;
        for (int b = 1; b <= 24; b++) e[b] = l[24 - b];
        for (int b = 33; b <= 56; b++) e[b] = r[56 - b];
        return e;
    endfunction

    // Called at a negedge; the DUT samples the strobe on the next posedge.
    task automatic do_wrt(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        lft_in  = l;
        rght_in = r;
        wrt     = 1'b1;
        @(negedge clk);
        wrt     = 1'b0;
    endtask

    // Wait (bounded) for the next frm_start pulse; report full just before it.
    task automatic wait_frm(output logic full_before);
        bit found;
        found       = 0;
        full_before = full;
        for (int i = 0; i < 3000 && !found; i++) begin
            full_before = full;
            @(negedge clk);
            if (frm_start) found = 1;
        end
        check("frm_timeout", 64'(found), 64'd1);
        if (last_frm >= 0) check("frm_period", 64'(cyc - last_frm), 64'(FRAME));
        last_frm = cyc;
    endtask

    // Starts at the negedge where frm_start is seen; samples every sclk
    // rise of the frame and compares data and word select.
    task automatic check_frame(input string tag, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        logic [63:0] d, w;
        logic        sclk_hi, pulse_after;
        sclk_hi = 1'b1;
        @(negedge clk);
        pulse_after = frm_start | undrn;
        repeat (15) @(negedge clk);
        for (int b = 0; b < 64; b++) begin
            d[b]    = I2S_data;
            w[b]    = I2S_ws;
            sclk_hi = sclk_hi & I2S_sclk;
            if (b != 63) repeat (32) @(negedge clk);
        end
        check({tag, "_pulse_width"}, 64'(pulse_after), 64'd0);
        check({tag, "_sclk_phase"}, 64'(sclk_hi), 64'd1);
        check({tag, "_ws"}, w, {32'hFFFF_FFFF, 32'h0});
        check({tag, "_data"}, d, exp_bits(l, r));
    endtask

    // Asserts reset at a negedge, checks reset values at once, releases.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_sclk"}, 64'(I2S_sclk), 64'd0);
        check({tag, "_rst_ws"}, 64'(I2S_ws), 64'd1);
        check({tag, "_rst_data"}, 64'(I2S_data), 64'd0);
        check({tag, "_rst_full"}, 64'(full), 64'd0);
        check({tag, "_rst_frm"}, 64'(frm_start), 64'd0);
        check({tag, "_rst_undrn"}, 64'(undrn), 64'd0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        last_frm = -1;
    endtask

    // Idle timing right after release: ws falls at clk 32, underrun frames of zeros.
    task automatic check_idle(input string tag);
        logic fb;
        repeat (15) @(negedge clk);
        check({tag, "_sclk_before_rise"}, 64'(I2S_sclk), 64'd0);
        @(negedge clk);
        check({tag, "_sclk_first_rise"}, 64'(I2S_sclk), 64'd1);
        repeat (15) @(negedge clk);
        check({tag, "_ws_before_32"}, 64'(I2S_ws), 64'd1);
        check({tag, "_frm_before_32"}, 64'(frm_start), 64'd0);
        @(negedge clk);
        check({tag, "_ws_at_32"}, 64'(I2S_ws), 64'd0);
        check({tag, "_frm_at_32"}, 64'(frm_start), 64'd1);
        check({tag, "_undrn_at_32"}, 64'(undrn), 64'd1);
        last_frm = cyc;
        check_frame({tag, "_f0"}, '0, '0);
        wait_frm(fb);
        check({tag, "_undrn_f1"}, 64'(undrn), 64'd1);
    endtask

    initial begin
        logic fb;
        int   e5, e8;

        // Reset / idle.
        @(negedge clk);
        apply_reset("idle");
        check_idle("idle");

        // Single frame: write before the first load.
        @(negedge clk);
        apply_reset("single");
        do_wrt(24'hA5C3F0, 24'h123456);
        check("single_full_set", 64'(full), 64'd1);
        wait_frm(fb);
        check("single_undrn", 64'(undrn), 64'd0);
        check("single_full_drop", 64'(full), 64'd0);
        check_frame("single", 24'hA5C3F0, 24'h123456);

        // Underrun repeat: one write, three loads.
        do_wrt(24'h7FFFFF, 24'h800000);
        for (int k = 1; k <= 3; k++) begin
            wait_frm(fb);
            check($sformatf("urun_full_before_l%0d", k), 64'(fb), (k == 1) ? 64'd1 : 64'd0);
            check($sformatf("urun_undrn_l%0d", k), 64'(undrn), (k == 1) ? 64'd0 : 64'd1);
            check_frame($sformatf("urun_l%0d", k), 24'h7FFFFF, 24'h800000);
        end

        // Overwrite: two writes within one frame, only the last is sent.
        wait_frm(fb);
        check("ovr_undrn_pre", 64'(undrn), 64'd1);
        do_wrt(24'h111111, 24'h111111);
        check("ovr_full_1", 64'(full), 64'd1);
        do_wrt(24'h222222, 24'h222222);
        check("ovr_full_2", 64'(full), 64'd1);
        wait_frm(fb);
        check("ovr_full_before", 64'(fb), 64'd1);
        check("ovr_undrn", 64'(undrn), 64'd0);
        check("ovr_full_after", 64'(full), 64'd0);
        e5 = cyc;
        check_frame("ovr", 24'h222222, 24'h222222);

        // Simultaneous: write lands on the load edge itself.
        do_wrt(24'h444444, 24'h444444);
        while (cyc < e5 + FRAME - 1) @(negedge clk);
        lft_in  = 24'h333333;
        rght_in = 24'h333333;
        wrt     = 1'b1;
        @(negedge clk);
        wrt     = 1'b0;
        check("sim_frm_on_load", 64'(frm_start), 64'd1);
        check("sim_undrn", 64'(undrn), 64'd0);
        check("sim_full_after", 64'(full), 64'd1);
        last_frm = cyc;
        check_frame("sim_a", 24'h444444, 24'h444444);
        wait_frm(fb);
        check("sim_undrn_b", 64'(undrn), 64'd0);
        check_frame("sim_b", 24'h333333, 24'h333333);

        // Reset mid-frame with a pending sample.
        do_wrt(24'h555555, 24'h555555);
        wait_frm(fb);
        e8 = cyc;
        do_wrt(24'h666666, 24'h666666);
        while (cyc < e8 + 40 * 32 + 5) @(negedge clk);
        check("midrst_full_pre", 64'(full), 64'd1);
        check("midrst_ws_pre", 64'(I2S_ws), 64'd1);
        apply_reset("midrst");
        check_idle("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
